// File: rtl/sd_clk_ctrl.sv
// SD card bus clock sequencer and gate.
// Derives sd_clk from clk at identification speed or transfer speed, runs the
// power-up warm-up burst with CMD held high, changes speed only while sd_clk is
// low, and parks sd_clk low whenever no requester needs it.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | sd_clk parked low, half counter held at 0
// INIT  | warm-up burst: slow clock, rising edges counted, CMD forced high
// RUN   | clock running for a requester at the applied speed

module sd_clk_ctrl #(
    parameter int SLOW_HALF   = 62,
    parameter int FAST_HALF   = 1,
    parameter int INIT_CYCLES = 80
) (
    input  logic clk,
    input  logic res_n,
    input  logic init_start,
    input  logic clk_run,
    input  logic speed_req,
    output logic speed,
    output logic speed_ack,
    output logic sd_clk,
    output logic sd_clk_rise,
    output logic sd_clk_fall,
    output logic init_busy,
    output logic init_done,
    output logic cmd_force_high
);

    localparam int MAX_HALF = (SLOW_HALF > FAST_HALF) ? SLOW_HALF : FAST_HALF;
    localparam int HC_W     = (MAX_HALF > 1) ? $clog2(MAX_HALF) : 1;
    localparam int EC_W     = $clog2(INIT_CYCLES + 1);

    localparam logic [HC_W-1:0] SLOW_LAST = HC_W'(SLOW_HALF - 1);
    localparam logic [HC_W-1:0] FAST_LAST = HC_W'(FAST_HALF - 1);
    localparam logic [EC_W-1:0] EC_LOAD   = EC_W'(INIT_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_INIT = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic [HC_W-1:0] hc;
    logic [EC_W-1:0] ec;          // rising edges still owed by the burst
    logic            init_pend;   // burst restart waiting for the high half to end

    logic [HC_W-1:0] hc_last;
    logic            toggle_en;
    logic            hc_term;
    logic            init_last;
    logic            go_init;
    logic            spd_apply;

    // State register.
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state decision.
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: begin
                if (go_init) begin
                    state_nx = ST_INIT;
                end else if (clk_run) begin
                    state_nx = ST_RUN;
                end
            end
            ST_INIT: begin
                if (init_last) begin
                    state_nx = clk_run ? ST_RUN : ST_IDLE;
                end
            end
            ST_RUN: begin
                if (go_init) begin
                    state_nx = ST_INIT;
                end else if (!clk_run && !sd_clk) begin
                    state_nx = ST_IDLE;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // Edge strobes and control decode; a started high half always completes.
    always_comb begin
        hc_last        = speed ? FAST_LAST : SLOW_LAST;
        toggle_en      = (state != ST_IDLE) && (init_busy || clk_run || sd_clk);
        hc_term        = toggle_en && (hc == hc_last);
        sd_clk_rise    = hc_term && !sd_clk;
        sd_clk_fall    = hc_term && sd_clk;
        cmd_force_high = init_busy;
        init_last      = (state == ST_INIT) && sd_clk_fall && (ec == '0);
        go_init        = ((state == ST_IDLE) && init_start) ||
                         ((state == ST_RUN) && (init_start || init_pend) &&
                          (!sd_clk || sd_clk_fall));
        // Speed may only move while sd_clk is (about to be) low, so no pulse
        // is ever shorter than the shorter of the two half periods.
        spd_apply      = (speed_req != speed) && !go_init &&
                         ((state == ST_IDLE) ||
                          ((state == ST_RUN) && sd_clk_fall) ||
                          init_last);
    end

    // Clock divider, burst edge counter, speed and status registers.
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            hc        <= '0;
            ec        <= '0;
            sd_clk    <= 1'b0;
            speed     <= 1'b0;
            speed_ack <= 1'b0;
            init_busy <= 1'b0;
            init_done <= 1'b0;
            init_pend <= 1'b0;
        end else begin
            sd_clk <= sd_clk ^ hc_term;

            if ((state == ST_IDLE) || (state_nx != state) || spd_apply) begin
                hc <= '0;
            end else if (toggle_en) begin
                hc <= hc_term ? '0 : hc + 1'b1;
            end

            if (go_init) begin
                ec <= EC_LOAD;
            end else if ((state == ST_INIT) && sd_clk_rise) begin
                ec <= ec - 1'b1;
            end

            // The burst always runs at identification speed; a pending
            // request is picked up again once the burst ends.
            if (go_init) begin
                speed <= 1'b0;
            end else if (spd_apply) begin
                speed <= speed_req;
            end
            speed_ack <= spd_apply;

            init_busy <= (state_nx == ST_INIT);
            if (init_last) begin
                init_done <= 1'b1;
            end

            if (go_init || (state != ST_RUN)) begin
                init_pend <= 1'b0;
            end else if (init_start && sd_clk) begin
                init_pend <= 1'b1;
            end
        end
    end

endmodule
